dynamic_display_scanner: RTL

Parametrised multiplexed 7-segment display driver with a built-in prescaler, scanning DIGITS common-anode digits one at a time. It sits between the datapath result registers and the board's segment/anode pins. Over the fixed 2-bit scan counter it adds:

- a configurable digit count;
- a frame-coherent data snapshot;
- PWM brightness;
- an inter-digit dead cycle against ghosting;
- leading-zero suppression;
- a frame-boundary strobe.

---
 rtl/dynamic_display_scanner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dynamic_display_scanner.sv
// Multiplexed common-anode 7-segment scanner with a prescaler, frame-coherent snapshot,
// PWM brightness, dead cycle, leading-zero suppression and frame strobe.
module dynamic_display_scanner #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned DUTY_BITS = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [4*DIGITS-1:0]        DATA,
  input  logic [DIGITS-1:0]          DP,
  input  logic                       LZ_BLANK,
  input  logic [DUTY_BITS-1:0]       BRIGHT,
  output logic [DIGITS-1:0]          DIGIT_SEL,
  output logic [7:0]                 SEG,
  output logic [$clog2(DIGITS)-1:0]  SCAN_IDX,
  output logic                       FRAME_TICK
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned TW = DUTY_BITS + CW + 1;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   started;
  logic [4*DIGITS-1:0]    sh_data;
  logic [DIGITS-1:0]      sh_dp;
  logic                   sh_lz;
  logic [DUTY_BITS-1:0]   sh_bright;

  logic                   slot_end;
  logic                   frame_end;
  logic [CW-1:0]          cnt_nxt;
  logic [IW-1:0]          idx_nxt;
  logic [TW-1:0]          prod;
  logic [TW-1:0]          thr;
  logic                   lit;
  logic [3:0]             nibs [DIGITS];
  logic [DIGITS-1:0]      blank;
  logic                   allz;
  logic [6:0]             font;
  logic [7:0]             seg_on;

  // Slot/frame counters: modulo-PRESCALE prescaler feeding a modulo-DIGITS index
  always_comb begin
    slot_end  = (cnt == CW'(PRESCALE - 1));
    frame_end = slot_end && (idx == IW'(DIGITS - 1));
    cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
    idx_nxt   = idx;
    if (slot_end) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // PWM threshold, wide enough that (BRIGHT+1)*(PRESCALE-1) cannot overflow
  always_comb begin
    prod = (TW'(sh_bright) + TW'(1)) * TW'(PRESCALE - 1);
    thr  = prod >> DUTY_BITS;
    if (thr == '0) thr = TW'(1);
    lit  = (cnt != '0) && (TW'(cnt) <= thr);
  end

  // Digit i is blanked when it and all higher nibbles are zero; digit 0 never is
  always_comb begin
    blank = '0;
    allz  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) nibs[i] = sh_data[4*i +: 4];
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      allz     = allz & (nibs[i] == 4'h0);
      blank[i] = sh_lz & allz & (i != 0);
    end
  end

  always_comb begin
    font = 7'h7F;
    case (nibs[idx])
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;
      4'hF: font = 7'b0001110;
      default: font = 7'h7F;
    endcase
    seg_on = {~sh_dp[idx], blank[idx] ? 7'h7F : font};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      started    <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      sh_bright  <= '0;
      DIGIT_SEL  <= '1;
      SEG        <= '1;
      SCAN_IDX   <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      SCAN_IDX   <= idx;
      FRAME_TICK <= 1'b0;
      DIGIT_SEL  <= '1;
      SEG        <= '1;
      if (EN) begin
        cnt        <= cnt_nxt;
        idx        <= idx_nxt;
        started    <= 1'b1;
        FRAME_TICK <= frame_end;
        // Snapshot only at frame boundaries so a frame never mixes two input values
        if (!started || frame_end) begin
          sh_data   <= DATA;
          sh_dp     <= DP;
          sh_lz     <= LZ_BLANK;
          sh_bright <= BRIGHT;
        end
        if (lit) begin
          DIGIT_SEL <= ~(DIGITS'(1) << idx);
          SEG       <= seg_on;
        end
      end
    end
  end

endmodule
